hilo_madd_sequencer: RTL and testbench
======================================

# hilo_madd_sequencer

Issue-side controller for the multi-cycle 32x32+64 multiply/add/sub DSP unit: accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO from the EX stage, drives the unit's start/busy handshake, and owns the architectural HI/LO registers. It sits between the integer pipeline and the DSP unit. It also stalls MFHI/MFLO reads until any in-flight result has been written back.

## Interface
- TIMEOUT, 64: cycles in WAIT before the sticky `err_timeout` flag sets.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- op_valid  in  1  operation present this cycle.
- op_code  in  3  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 MTHI, 7 MTLO.
- op_rs, op_rt  in  32  operands. MTHI/MTLO use op_rs only.
- op_ready  out  1  op accepted when op_valid & op_ready.
- rd_req  in  1  MFHI/MFLO request.
- rd_sel  in  1  0 LO, 1 HI.
- rd_data  out  32  selected register, valid when rd_req & ~stall.
- stall  out  1  rd_req & (state != IDLE).
- dsp_A, dsp_B  out  32  operands to the unit.
- dsp_C  out  64  {HI,LO} addend.
- dsp_sign, dsp_fused, dsp_subtract, dsp_start  out  1  control to the unit.
- dsp_busy  in  1  unit busy.
- dsp_D  in  65  unit result. Bit 64 is ignored.
- hi, lo  out  32  architectural HI/LO.
- err_timeout  out  1  sticky; cleared only by reset.

## Operation
- States: IDLE, ISSUE, GUARD, WAIT, WB.
- IDLE, accepted multiply-family op:
  - Latch A=rs, B=rt, C={hi,lo}.
  - sign = ~op_code[0].
  - fused = op_code in {2..5}.
  - subtract = op_code in {4,5}.
  - Go to ISSUE.
- IDLE, accepted MTHI/MTLO: write HI or LO on the next edge. State stays IDLE.
- ISSUE: dsp_start=1 for exactly this cycle, then GUARD.
- GUARD: one cycle with dsp_busy ignored, because the unit's busy lags start. Then WAIT.
- WAIT: remain until dsp_busy=0, then WB.
- WB: HI<=dsp_D[63:32], LO<=dsp_D[31:0], then IDLE.
- DSP outputs hold their latched values from ISSUE through WB.
- op_ready:
  - 1 in IDLE.
  - With restart (see Configuration), also 1 in ISSUE/GUARD/WAIT for multiply-family ops.
  - MTHI/MTLO always require IDLE.
  - 0 in WB.
- Restart (mid-op accept):
  - Re-latch operands; C is taken from current hi/lo, which is unchanged by the aborted op.
  - Go to ISSUE.
  - The aborted op never writes HI/LO.
- Timeout counter: cleared on entry to WAIT, increments each WAIT cycle. Reaching TIMEOUT sets err_timeout and forces WB.
- rd_req with MTHI/MTLO the same cycle in IDLE: read returns the old value (write takes effect next edge).

## Timing
- Reset (reset=0 at an edge):
  - State IDLE; hi=lo=0; all dsp_* outputs 0; err_timeout=0; timeout counter 0.
  - Reset mid-operation abandons the op; no writeback.
- Latency:
  - Accept edge -> ISSUE (1 cycle) -> GUARD (1) -> WAIT (N ≥ 1, while busy) -> WB (1).
  - HI/LO are visible the cycle after WB.
  - stall deasserts in that same cycle.
- dsp_start is never high for two consecutive cycles, except back-to-back restarts.
- rd_data is combinational from hi/lo.

## Configuration
- HILO_RESTART_EN
  - Defined: multiply-family ops are accepted in ISSUE/GUARD/WAIT and restart the unit, relying on the unit's interrupt-and-restart behaviour.
  - Undefined: op_ready = (state == IDLE) for all ops.

## Structure
- Shared package holds:
  - the op_code encoding constants;
  - the state enum;
  - the HI/LO width and the derived 64-bit accumulator width.
- Optional sub-module `hilo_timeout_counter` (load/enable/terminal-count); otherwise the block is flat.

## Test plan
- MULTU rs=0x12345678, rt=0xffffffff, HI:LO=0 -> after WB hi=0x12345677, lo=0xedcba988; stall asserted until then.
- MTHI 0xffffffff, MTLO 0xffffffff, then MADD rs=rt=0xffffffff -> hi=lo=0.
- MTLO 80, MTHI 0, MSUBU rs=5, rt=7 -> lo=45, hi=0; exactly one dsp_start pulse observed.
- MULTU 0x12345678*0xffffffff, then after 3 cycles MULTU 0x1234*7:
  - with HILO_RESTART_EN: two start pulses; final hi=0, lo=0x7f6c; no intermediate writeback.
  - without: op_ready=0 until IDLE.
- Model dsp_busy stuck high, TIMEOUT=64 -> err_timeout=1 after 64 WAIT cycles; WB occurs; state returns to IDLE.
- Reset asserted in WAIT -> next cycle hi=lo=0, IDLE, op_ready=1, dsp_start=0.

Source files
------------

// File: rtl/hilo_madd_sequencer_pkg.sv
// rtl/hilo_madd_sequencer_pkg.sv - shared encodings and widths for the HI/LO multiply-add sequencer
// Purpose: op_code encodings, FSM state enum, HI/LO and accumulator widths,
//          and the multiply-family decode helper.
// Ports:   none (package).
package hilo_madd_sequencer_pkg;

    localparam int HILO_W = 32;
    localparam int ACC_W  = 2 * HILO_W;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MADDU = 3'd3;
    localparam logic [2:0] OP_MSUB  = 3'd4;
    localparam logic [2:0] OP_MSUBU = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_GUARD = 3'd2,
        S_WAIT  = 3'd3,
        S_WB    = 3'd4
    } state_t;

    // Everything except MTHI/MTLO goes through the DSP unit.
    function automatic logic is_mul_family(input logic [2:0] code);
        return (code != OP_MTHI) && (code != OP_MTLO);
    endfunction

endpackage

// File: rtl/hilo_madd_sequencer_timeout_counter.sv
// rtl/hilo_madd_sequencer_timeout_counter.sv - WAIT-state timeout counter
// Purpose: counts enabled cycles after a load; terminal flags the TERMINAL-th
//          enabled cycle (the count reached so far is TERMINAL-1).
// Ports:   clock, reset (sync active-low), load (clear), enable (count),
//          terminal (this enabled cycle is the TERMINAL-th one).
module hilo_timeout_counter #(
    parameter int TERMINAL = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic terminal
);

    localparam int CW = $clog2(TERMINAL + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset || load) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = enable && (count == CW'(TERMINAL - 1));

endmodule

// File: rtl/hilo_madd_sequencer.sv
// rtl/hilo_madd_sequencer.sv - issue controller for the multiply/add DSP unit, owns HI/LO
// Purpose: accepts MULT..MSUBU/MTHI/MTLO, sequences ISSUE/GUARD/WAIT/WB against
//          the DSP start/busy handshake, writes back HI/LO and stalls MFHI/MFLO.
// Config:  HILO_RESTART_EN - when defined, multiply-family ops are also accepted
//          in ISSUE/GUARD/WAIT and restart the unit (aborted op never writes back).
// Ports:   clock, reset (sync active-low); op_valid/op_code/op_rs/op_rt/op_ready
//          (op issue); rd_req/rd_sel/rd_data/stall (HI/LO read); dsp_A/B/C,
//          dsp_sign/fused/subtract/start, dsp_busy, dsp_D (unit); hi, lo,
//          err_timeout (sticky timeout flag).
module hilo_madd_sequencer
    import hilo_madd_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [HILO_W-1:0] op_rs,
    input  logic [HILO_W-1:0] op_rt,
    output logic              op_ready,
    input  logic              rd_req,
    input  logic              rd_sel,
    output logic [HILO_W-1:0] rd_data,
    output logic              stall,
    output logic [HILO_W-1:0] dsp_A,
    output logic [HILO_W-1:0] dsp_B,
    output logic [ACC_W-1:0]  dsp_C,
    output logic              dsp_sign,
    output logic              dsp_fused,
    output logic              dsp_subtract,
    output logic              dsp_start,
    input  logic              dsp_busy,
    input  logic [ACC_W:0]    dsp_D,
    output logic [HILO_W-1:0] hi,
    output logic [HILO_W-1:0] lo,
    output logic              err_timeout
);

`ifdef HILO_RESTART_EN
    localparam bit RESTART_EN = 1'b1;
`else
    localparam bit RESTART_EN = 1'b0;
`endif

    state_t state, next_state;
    logic   accept_mul, accept_mt, tmo_terminal, timeout_hit;
    logic   unused_carry;

    // Carry-out of the unit is not architectural.
    assign unused_carry = dsp_D[ACC_W];

    hilo_timeout_counter #(.TERMINAL(TIMEOUT)) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .load     (state == S_GUARD),
        .enable   (state == S_WAIT),
        .terminal (tmo_terminal)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        op_ready   = 1'b0;
        case (state)
            S_IDLE:                   op_ready = 1'b1;
            S_ISSUE, S_GUARD, S_WAIT: op_ready = RESTART_EN && is_mul_family(op_code);
            default:                  op_ready = 1'b0;
        endcase

        accept_mul  = op_valid && op_ready && is_mul_family(op_code);
        accept_mt   = op_valid && op_ready && !is_mul_family(op_code);
        // A restart in the same cycle as the timeout takes precedence.
        timeout_hit = (state == S_WAIT) && dsp_busy && tmo_terminal && !accept_mul;

        case (state)
            S_ISSUE: next_state = S_GUARD;
            S_GUARD: next_state = S_WAIT;
            S_WAIT:  if (!dsp_busy || timeout_hit) next_state = S_WB;
            S_WB:    next_state = S_IDLE;
            default: next_state = state;
        endcase
        // Covers both the IDLE accept and a mid-operation restart.
        if (accept_mul) next_state = S_ISSUE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hi           <= '0;
            lo           <= '0;
            dsp_A        <= '0;
            dsp_B        <= '0;
            dsp_C        <= '0;
            dsp_sign     <= 1'b0;
            dsp_fused    <= 1'b0;
            dsp_subtract <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (accept_mul) begin
                dsp_A        <= op_rs;
                dsp_B        <= op_rt;
                dsp_C        <= {hi, lo};
                dsp_sign     <= ~op_code[0];
                dsp_fused    <= (op_code >= OP_MADD);
                dsp_subtract <= (op_code >= OP_MSUB);
            end
            if (accept_mt) begin
                if (op_code == OP_MTHI) hi <= op_rs;
                else                    lo <= op_rs;
            end
            if (state == S_WB) begin
                hi <= dsp_D[ACC_W-1:HILO_W];
                lo <= dsp_D[HILO_W-1:0];
            end
            if (timeout_hit) err_timeout <= 1'b1;
        end
    end

    assign dsp_start = (state == S_ISSUE);
    assign stall     = rd_req && (state != S_IDLE);
    assign rd_data   = rd_sel ? hi : lo;

endmodule

// File: tb/tb_hilo_madd_sequencer.sv
// tb/tb_hilo_madd_sequencer.sv - directed self-checking bench for hilo_madd_sequencer
module tb_hilo_madd_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] op_rs = '0, op_rt = '0;
    logic        op_ready;
    logic        rd_req = 1'b0, rd_sel = 1'b0;
    logic [31:0] rd_data;
    logic        stall;
    logic [31:0] dsp_A, dsp_B;
    logic [63:0] dsp_C;
    logic        dsp_sign, dsp_fused, dsp_subtract, dsp_start, dsp_busy;
    logic [64:0] dsp_D;
    logic [31:0] hi, lo;
    logic        err_timeout;

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    hilo_madd_sequencer dut (
        .clock(clock), .reset(reset),
        .op_valid(op_valid), .op_code(op_code), .op_rs(op_rs), .op_rt(op_rt),
        .op_ready(op_ready), .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data),
        .stall(stall), .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_C(dsp_C),
        .dsp_sign(dsp_sign), .dsp_fused(dsp_fused), .dsp_subtract(dsp_subtract),
        .dsp_start(dsp_start), .dsp_busy(dsp_busy), .dsp_D(dsp_D),
        .hi(hi), .lo(lo), .err_timeout(err_timeout)
    );

    // DSP unit model: busy follows start by one cycle, lasts 3 cycles,
    // restarts on a new start; stuck forces busy high.
    int   busy_cnt = 0;
    logic stuck = 1'b0;
    int   starts = 0;
    int   inter_cnt = 0;

    function automatic logic [63:0] dsp_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [63:0] c, input logic sgn,
                                              input logic fus, input logic sub);
        logic [63:0] p;
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (sgn) p = sa * sb;
        else     p = {32'b0, a} * {32'b0, b};
        if (!fus)     return p;
        else if (sub) return c - p;
        else          return c + p;
    endfunction

    assign dsp_busy = stuck || (busy_cnt != 0);

    always @(posedge clock) begin
        if (!reset) begin
            busy_cnt <= 0;
            dsp_D    <= '0;
        end else if (dsp_start) begin
            busy_cnt <= 3;
            dsp_D    <= {1'b1, dsp_model(dsp_A, dsp_B, dsp_C, dsp_sign, dsp_fused, dsp_subtract)};
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    always @(posedge clock) if (dsp_start) starts <= starts + 1;
    always @(negedge clock) if (hi == 32'h12345677) inter_cnt <= inter_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] code, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clock);
        op_valid = 1'b1; op_code = code; op_rs = rs; op_rt = rt;
        @(negedge clock);
        op_valid = 1'b0;
    endtask

    // Counts stall cycles (rd_req held) until IDLE; err_n = first stall cycle with err_timeout.
    task automatic wait_idle(output int n, output int err_n);
        n = 0; err_n = 0; rd_req = 1'b1; #1;
        while (stall && n < 300) begin
            n++;
            if (err_timeout && err_n == 0) err_n = n;
            @(negedge clock); #1;
        end
        rd_req = 1'b0;
    endtask

    int n, en, s0, i0;

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_op_ready", 64'(op_ready), 64'd1);
        check("reset_dsp_start", 64'(dsp_start), 64'd0);
        check("reset_dsp_C", dsp_C, 64'd0);
        check("reset_err", 64'(err_timeout), 64'd0);
        reset = 1'b1;

        // MULTU 0x12345678 * 0xffffffff
        do_op(3'd1, 32'h12345678, 32'hffffffff);
        #1;
        check("multu_start", 64'(dsp_start), 64'd1);
        check("multu_A", 64'(dsp_A), 64'h12345678);
        check("multu_sign", 64'(dsp_sign), 64'd0);
        check("multu_fused", 64'(dsp_fused), 64'd0);
        wait_idle(n, en);
        check("multu_stall_cycles", 64'(n), 64'd6);
        check("multu_hi", 64'(hi), 64'h12345677);
        check("multu_lo", 64'(lo), 64'hedcba988);

        // MTHI/MTLO then MADD -1*-1 + (-1)
        do_op(3'd6, 32'hffffffff, 32'd0);
        @(negedge clock);
        op_valid = 1'b1; op_code = 3'd7; op_rs = 32'hffffffff;
        rd_req = 1'b1; rd_sel = 1'b0; #1;
        check("mtlo_read_old", 64'(rd_data), 64'hedcba988);
        check("mtlo_no_stall", 64'(stall), 64'd0);
        @(negedge clock);
        op_valid = 1'b0; rd_req = 1'b0;
        do_op(3'd2, 32'hffffffff, 32'hffffffff);
        #1;
        check("madd_C", dsp_C, 64'hffffffffffffffff);
        check("madd_sign", 64'(dsp_sign), 64'd1);
        check("madd_fused", 64'(dsp_fused), 64'd1);
        check("madd_subtract", 64'(dsp_subtract), 64'd0);
        wait_idle(n, en);
        check("madd_hi", 64'(hi), 64'd0);
        check("madd_lo", 64'(lo), 64'd0);

        // MTLO 80, MTHI 0, MSUBU 5*7 -> 45
        do_op(3'd7, 32'd80, 32'd0);
        do_op(3'd6, 32'd0, 32'd0);
        s0 = starts;
        do_op(3'd5, 32'd5, 32'd7);
        #1;
        check("msubu_subtract", 64'(dsp_subtract), 64'd1);
        check("msubu_sign", 64'(dsp_sign), 64'd0);
        wait_idle(n, en);
        check("msubu_lo", 64'(lo), 64'd45);
        check("msubu_hi", 64'(hi), 64'd0);
        check("msubu_one_start", 64'(starts - s0), 64'd1);

        // Second MULTU presented while the first is in WAIT
        s0 = starts; i0 = inter_cnt;
        do_op(3'd1, 32'h12345678, 32'hffffffff);
        @(negedge clock);
        @(negedge clock);
        op_valid = 1'b1; op_code = 3'd1; op_rs = 32'h1234; op_rt = 32'd7; #1;
`ifdef HILO_RESTART_EN
        check("restart_op_ready", 64'(op_ready), 64'd1);
`else
        check("norestart_op_ready", 64'(op_ready), 64'd0);
        n = 0;
        while (!op_ready && n < 100) begin
            n++;
            @(negedge clock); #1;
        end
        check("norestart_wait_cycles", 64'(n), 64'd4);
`endif
        @(negedge clock);
        op_valid = 1'b0;
        wait_idle(n, en);
        check("second_hi", 64'(hi), 64'd0);
        check("second_lo", 64'(lo), 64'h7f6c);
        check("second_two_starts", 64'(starts - s0), 64'd2);
`ifdef HILO_RESTART_EN
        check("restart_no_wb", 64'(inter_cnt - i0 != 0), 64'd0);
`else
        check("norestart_first_wb", 64'(inter_cnt - i0 != 0), 64'd1);
`endif

        // Timeout with busy stuck high
        check("pre_timeout_err", 64'(err_timeout), 64'd0);
        stuck = 1'b1;
        do_op(3'd1, 32'd3, 32'd4);
        wait_idle(n, en);
        check("timeout_stall_cycles", 64'(n), 64'd67);
        check("timeout_err_first_in_wb", 64'(en), 64'd67);
        check("timeout_err", 64'(err_timeout), 64'd1);
        check("timeout_lo", 64'(lo), 64'd12);
        check("timeout_idle_ready", 64'(op_ready), 64'd1);
        stuck = 1'b0;

        // Reset while in WAIT
        do_op(3'd1, 32'd2, 32'd3);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        rd_req = 1'b1; #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_op_ready", 64'(op_ready), 64'd1);
        check("rst_dsp_start", 64'(dsp_start), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        check("rst_dsp_A", 64'(dsp_A), 64'd0);
        rd_req = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        check("rst_no_writeback", 64'(lo), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
